ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//   Instruction prefetch stage between instruction memory and decode.
//   - Generates sequential fetch addresses; issues in-order requests to imem.
//   - Buffers {pc, instr} pairs in a DEPTH-entry FIFO.
//   - Hands them to decode over a valid/ready handshake.
//   - Accepts redirects from exec (branch/jump): flushes the queue and discards in-flight responses.
// PARAMETERS
//   DEPTH            4        queue entries; power of 2, >= 2
//   MAX_OUTSTANDING  2        max imem requests in flight, 1..DEPTH
//   RESET_PC         32'h0    first fetch address after reset
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   asynchronous, active-high reset
//   imem_req_valid  out  1   request valid
//   imem_req_ready  in   1   memory accepts request
//   imem_req_addr   out  32  word-aligned fetch address
//   imem_rsp_valid  in   1   response valid; in order, always accepted
//   imem_rsp_data   in   32  instruction word
//   out_valid       out  1   head entry valid toward decode
//   out_ready       in   1   decode accepts head entry
//   out_pc          out  32  pc of head entry
//   out_instr       out  32  instruction of head entry
//   redirect_valid  in   1   redirect request from exec
//   redirect_pc     in   32  redirect target
// BEHAVIOUR
//   Reset (async): fetch_pc=RESET_PC; count=0; outstanding=0; drop_cnt=0; rd/wr ptr=0.
//     - While rst is high, all outputs are 0.
//   imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING && (count+outstanding)<DEPTH.
//     - Asserts first cycle after rst falls.
//   imem_req_addr = fetch_pc.
//     - Held stable while valid && !ready.
//     - On handshake, fetch_pc += 4, mod 2^32 (wraps).
//   Credit rule: count+outstanding <= DEPTH always, so every response has a free slot.
//     - A response never arrives into a full queue.
//   Response handling:
//     - drop_cnt==0: write {pc,data} at wr_ptr. pc comes from an internal in-order pc tag.
//     - drop_cnt>0: discard the response; drop_cnt--.
//     - Either way, outstanding--.
//   Latency: response at cycle N gives out_valid at N+1 (registered, no bypass).
//   out_valid = (count!=0); out_pc/out_instr = head entry.
//     - Dequeue on out_valid && out_ready; FIFO order is strict.
//   Same-cycle enqueue and dequeue: count unchanged; both pointers advance mod DEPTH.
//   Redirect (single-cycle pulse, highest priority):
//     - count<=0; ptrs<=0; fetch_pc<={redirect_pc[31:2],2'b00}.
//     - No request issued in the redirect cycle.
//     - drop_cnt <= outstanding after this cycle's response decrement.
//       A response arriving in the redirect cycle is itself discarded.
//     - A dequeue handshake in the same cycle completes; decode flushes it itself.
//   Effective modes: RUN (drop_cnt==0), FLUSH (drop_cnt>0).
//     - FLUSH -> RUN when drop_cnt reaches 0.
//     - New requests may issue during FLUSH, within credit limits.
//     - Redirect during FLUSH reloads drop_cnt with the current outstanding.
//   rst mid-operation: all state cleared immediately; subsequent late imem responses are the memory's responsibility.
// CONFIGURATION
//   IFQ_STATS_EN defined:
//     - Adds outputs stat_fetched[31:0] (enqueued instrs) and stat_dropped[31:0] (discarded responses).
//     - Free-running, wrapping, cleared by rst.
//   Undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//   1 Reset release, imem 1-cycle latency, ready=1 -> addrs 0,4,8,...; out_pc=0 cycle after first rsp; 1 instr/cycle steady.
//   2 out_ready=0, DEPTH=4 -> exactly 4 requests issued, then req_valid=0; release -> out_pc 0,4,8,C in order.
//   3 Redirect to 0x100 with 2 outstanding -> next 2 rsps dropped; next out_pc=0x100; stat_dropped=2 if IFQ_STATS_EN.
//   4 redirect_pc=0x102 -> imem_req_addr=0x100.
//   5 RESET_PC=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   6 imem_req_ready=0 for 3 cycles -> addr held constant; fetch_pc not incremented; resumes on ready=1.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetch feeding decode through a DEPTH-entry
// {pc, instr} FIFO, with redirect flush and in-flight response dropping.
// Optional feature macro IFQ_STATS_EN adds stat_fetched / stat_dropped counters.
module ifetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
`ifdef IFQ_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    // RUN accepts responses; FLUSH discards responses issued before a redirect.
    typedef enum logic {StRun, StFlush} mode_e;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;     // pc of the next response that will be kept
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]   mem_q [DEPTH];

    mode_e       mode;
    logic        credit_ok;
    logic        req_fire;
    logic        rsp_keep;
    logic        deq;
    logic [31:0] redirect_aligned;

    assign mode             = (drop_q == '0) ? StRun : StFlush;
    assign redirect_aligned = redirect_pc & ~32'h3;
    // Reserve a queue slot for every request in flight so responses never overflow.
    assign credit_ok        = ({1'b0, count_q} + {1'b0, outst_q}) < SW'(DEPTH);

    assign imem_req_valid = !rst && !redirect_valid && (outst_q < CW'(MAX_OUTSTANDING)) &&
                            credit_ok;
    assign imem_req_addr  = rst ? '0 : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = !rst && (count_q != '0);
    assign out_pc    = rst ? '0 : mem_q[rd_ptr_q][63:32];
    assign out_instr = rst ? '0 : mem_q[rd_ptr_q][31:0];
    assign deq       = out_valid && out_ready;

    // A response landing in a redirect cycle belongs to the old path.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (mode == StRun);

    // Next-state: redirect flushes the queue and converts in-flight requests to drops.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (mode == StFlush)) begin
                drop_d = drop_q - 1'b1;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(rsp_keep) - CW'(deq);
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful where count marks them valid.
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            mem_q[wr_ptr_q] <= {rsp_pc_q, imem_rsp_data};
        end
    end

`ifdef IFQ_STATS_EN
    logic rsp_drop;
    assign rsp_drop = imem_rsp_valid && !rsp_keep;

    // Free-running wrap-around counters of kept and discarded responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= stat_fetched + 32'(rsp_keep);
            stat_dropped <= stat_dropped + 32'(rsp_drop);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: main instance with a 1- or 2-cycle memory model,
// plus a second instance with RESET_PC near the top of the address space.
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req2_valid;
    logic        req2_ready;
    logic [31:0] req2_addr;
    logic        rsp2_valid;
    logic [31:0] rsp2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic [31:0] out2_pc;
    logic [31:0] out2_instr;
    logic        redir2_valid;
    logic [31:0] redir2_pc;

`ifdef IFQ_STATS_EN
    logic [31:0] stat_fetched, stat_dropped;
    logic [31:0] stat2_fetched, stat2_dropped;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 1;
    int req_cnt;

    logic        s1_v;
    logic [31:0] s1_a;

    ifetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef IFQ_STATS_EN
        .stat_fetched   (stat_fetched),
        .stat_dropped   (stat_dropped),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    ifetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req2_valid),
        .imem_req_ready (req2_ready),
        .imem_req_addr  (req2_addr),
        .imem_rsp_valid (rsp2_valid),
        .imem_rsp_data  (rsp2_data),
        .out_valid      (out2_valid),
        .out_ready      (out2_ready),
        .out_pc         (out2_pc),
        .out_instr      (out2_instr),
`ifdef IFQ_STATS_EN
        .stat_fetched   (stat2_fetched),
        .stat_dropped   (stat2_dropped),
`endif
        .redirect_valid (redir2_valid),
        .redirect_pc    (redir2_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model for the main instance: in-order, latency 1 or 2.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            s1_v           <= 1'b0;
            s1_a           <= '0;
            req_cnt        <= 0;
        end else begin
            s1_v <= imem_req_valid && imem_req_ready;
            s1_a <= imem_req_addr;
            if (lat == 1) begin
                imem_rsp_valid <= imem_req_valid && imem_req_ready;
                imem_rsp_data  <= instr_of(imem_req_addr);
            end else begin
                imem_rsp_valid <= s1_v;
                imem_rsp_data  <= instr_of(s1_a);
            end
            if (imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;
        end
    end

    // Memory model for the second instance: latency 1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp2_valid <= 1'b0;
            rsp2_data  <= '0;
        end else begin
            rsp2_valid <= req2_valid && req2_ready;
            rsp2_data  <= instr_of(req2_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req2_ready     = 1'b1;
        out2_ready     = 1'b1;
        redir2_valid   = 1'b0;
        redir2_pc      = '0;

        // Reset: all outputs low, even with a nonzero RESET_PC.
        step();
        check("rst_req_valid", imem_req_valid, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_dut2_addr", req2_addr, 32'd0);
`ifdef IFQ_STATS_EN
        check("rst_stat_fetched", stat_fetched, 32'd0);
        check("rst_stat_dropped", stat_dropped, 32'd0);
`endif

        // Streaming with 1-cycle memory; second instance checks address wrap.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t1_c0_req_valid", imem_req_valid, 32'd1);
        check("t1_c0_addr", imem_req_addr, 32'h0);
        check("t5_c0_addr", req2_addr, 32'hFFFF_FFF8);
        step();
        check("t1_c1_addr", imem_req_addr, 32'h4);
        check("t1_c1_out_valid", out_valid, 32'd0);
        check("t5_c1_addr", req2_addr, 32'hFFFF_FFFC);
        step();
        check("t1_c2_out_valid", out_valid, 32'd1);
        check("t1_c2_out_pc", out_pc, 32'h0);
        check("t1_c2_out_instr", out_instr, instr_of(32'h0));
        check("t1_c2_addr", imem_req_addr, 32'h8);
        check("t5_c2_addr", req2_addr, 32'h0);
        check("t5_c2_out_pc", out2_pc, 32'hFFFF_FFF8);
        step();
        check("t1_c3_out_pc", out_pc, 32'h4);
        check("t1_c3_addr", imem_req_addr, 32'hC);
        check("t5_c3_out_pc", out2_pc, 32'hFFFF_FFFC);
        step();
        check("t1_c4_out_pc", out_pc, 32'h8);
        check("t1_c4_out_instr", out_instr, instr_of(32'h8));
        check("t5_c4_out_pc", out2_pc, 32'h0);

        // Decode stalled: exactly DEPTH requests, then drain in order.
        out_ready = 1'b0;
        reset_dut();
        repeat (5) step();
        check("t2_req_cnt", req_cnt, 32'd4);
        check("t2_req_valid_off", imem_req_valid, 32'd0);
        check("t2_out_valid", out_valid, 32'd1);
        @(negedge clk);
        check("t2_req_cnt_held", req_cnt, 32'd4);
        out_ready = 1'b1;
        #1;
        check("t2_out_pc0", out_pc, 32'h0);
        step();
        check("t2_out_pc1", out_pc, 32'h4);
        step();
        check("t2_out_pc2", out_pc, 32'h8);
        step();
        check("t2_out_pc3", out_pc, 32'hC);
        check("t2_out_instr3", out_instr, instr_of(32'hC));

        // Redirect with two requests in flight (2-cycle memory).
        lat = 2;
        reset_dut();
        step();
        @(negedge clk);
        check("t3_outstanding", req_cnt, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_no_req_in_redirect", imem_req_valid, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t3_c3_req_valid", imem_req_valid, 32'd1);
        check("t3_c3_addr", imem_req_addr, 32'h100);
        check("t3_c3_out_valid", out_valid, 32'd0);
        step();
        check("t3_c4_out_valid", out_valid, 32'd0);
        step();
        check("t3_c5_out_valid", out_valid, 32'd0);
        step();
        check("t3_c6_out_valid", out_valid, 32'd1);
        check("t3_c6_out_pc", out_pc, 32'h100);
        check("t3_c6_out_instr", out_instr, instr_of(32'h100));
`ifdef IFQ_STATS_EN
        check("t3_stat_dropped", stat_dropped, 32'd2);
        check("t3_stat_fetched", stat_fetched, 32'd1);
`endif

        // Misaligned redirect target is word-aligned.
        lat = 1;
        reset_dut();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        check("t4_no_req_in_redirect", imem_req_valid, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t4_addr_aligned", imem_req_addr, 32'h100);
        check("t4_req_valid", imem_req_valid, 32'd1);
        step();
        step();
        check("t4_out_pc", out_pc, 32'h100);

        // Memory back-pressure holds the address.
        imem_req_ready = 1'b0;
        reset_dut();
        #1;
        check("t6_c0_addr", imem_req_addr, 32'h0);
        check("t6_c0_req_valid", imem_req_valid, 32'd1);
        step();
        check("t6_c1_addr", imem_req_addr, 32'h0);
        step();
        check("t6_c2_addr", imem_req_addr, 32'h0);
        check("t6_c2_req_cnt", req_cnt, 32'd0);
        @(negedge clk);
        imem_req_ready = 1'b1;
        #1;
        check("t6_c3_addr", imem_req_addr, 32'h0);
        step();
        check("t6_c4_addr", imem_req_addr, 32'h4);
        check("t6_c4_req_cnt", req_cnt, 32'd1);
        step();
        check("t6_c5_out_pc", out_pc, 32'h0);
        step();
        check("t6_c6_out_pc", out_pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
